// File: rtl/battle_menu_ctrl_if.sv
// Command handshake between the battle menu controller and the battle engine.
//   cmd_valid : a command is pending (menu controller drives)
//   cmd_id    : slot being issued, stable while cmd_valid (menu controller drives)
//   cmd_ready : battle engine accepts the command (engine drives)
interface battle_menu_ctrl_if;
   logic       cmd_valid;
   logic [2:0] cmd_id;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_id, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/battle_menu_ctrl.sv
// Cursor/selection controller for the battle menu box.
// Six slots: moves 0-3 on the bottom row, FIGHT (4) and RUN (5) on the top row.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   menu_en            engine requests a player choice
//   move_en[3:0]       per-move selectable flags
//   btn_up/down/left/right/a/b   debounced level buttons
//   cmd (master)       cmd_valid/cmd_id out, cmd_ready in
//   menu_vis           menu box shown
//   cursor[2:0]        highlighted slot
//   hl_on              highlight blink phase
module battle_menu_ctrl #(
   parameter logic [23:0] REPEAT_DELAY = 24'd12_500_000,
   parameter logic [23:0] REPEAT_RATE  = 24'd5_000_000,
   parameter logic [23:0] BLINK_CYCLES = 24'd6_250_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               menu_en,
   input  logic [3:0]         move_en,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               btn_a,
   input  logic               btn_b,
   battle_menu_ctrl_if.master cmd,
   output logic               menu_vis,
   output logic [2:0]         cursor,
   output logic               hl_on
);
   // After the first repeat tick the counter is rewound so that it reaches
   // REPEAT_DELAY again exactly REPEAT_RATE cycles later (REPEAT_RATE <= REPEAT_DELAY).
   localparam logic [23:0] REPEAT_RELOAD = REPEAT_DELAY - REPEAT_RATE + 24'd1;
   localparam logic [23:0] CNT_MAX       = 24'hFF_FFFF;

   typedef enum logic [1:0] {HIDDEN, BROWSE, ISSUE, WAIT_DROP} state_t;
   state_t state_reg, state_next;

   // Direction index: 0 up, 1 down, 2 left, 3 right
   logic [3:0] dir_btn;
   logic [3:0] dir_prev_reg;
   logic [3:0] dir_ev_reg;
   logic [3:0] dir_tick;
   logic       a_prev_reg, a_ev_reg;
   logic       b_prev_reg, b_ev_reg;

   logic [2:0]  cursor_reg, cursor_next;
   logic [2:0]  cmd_id_reg, cmd_id_next;
   logic        cmd_valid_reg, cmd_valid_next;
   logic [23:0] blink_cnt_reg;
   logic        blink_reg;

   assign dir_btn = {btn_right, btn_left, btn_down, btn_up};

   // Per-direction hold counters for auto-repeat
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_hold
         logic [23:0] hold_cnt_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               hold_cnt_reg <= '0;
            else if (!dir_btn[gi])
               hold_cnt_reg <= '0;
            else if (!dir_prev_reg[gi])
               hold_cnt_reg <= 24'd1;
            else if (hold_cnt_reg == REPEAT_DELAY)
               hold_cnt_reg <= REPEAT_RELOAD;
            else if (hold_cnt_reg != CNT_MAX)
               hold_cnt_reg <= hold_cnt_reg + 24'd1;
         end
         assign dir_tick[gi] = dir_btn[gi] & dir_prev_reg[gi] & (hold_cnt_reg == REPEAT_DELAY);
      end
   endgenerate

   // Events are registered, so the FSM acts one cycle after the detected edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir_prev_reg <= '0;
         dir_ev_reg   <= '0;
         a_prev_reg   <= 1'b0;
         a_ev_reg     <= 1'b0;
         b_prev_reg   <= 1'b0;
         b_ev_reg     <= 1'b0;
      end else begin
         dir_prev_reg <= dir_btn;
         dir_ev_reg   <= (dir_btn & ~dir_prev_reg) | dir_tick;
         a_prev_reg   <= btn_a;
         a_ev_reg     <= btn_a & ~a_prev_reg;
         b_prev_reg   <= btn_b;
         b_ev_reg     <= btn_b & ~b_prev_reg;
      end
   end

   // Blink runs only while browsing; any other state parks it at zero so
   // every entry into BROWSE starts from the same phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt_reg <= '0;
         blink_reg     <= 1'b0;
      end else if (state_reg != BROWSE) begin
         blink_cnt_reg <= '0;
         blink_reg     <= 1'b0;
      end else if (blink_cnt_reg >= BLINK_CYCLES - 24'd1) begin
         blink_cnt_reg <= '0;
         blink_reg     <= ~blink_reg;
      end else begin
         blink_cnt_reg <= blink_cnt_reg + 24'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= HIDDEN;
         cursor_reg    <= 3'd4;
         cmd_id_reg    <= 3'd0;
         cmd_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cursor_reg    <= cursor_next;
         cmd_id_reg    <= cmd_id_next;
         cmd_valid_reg <= cmd_valid_next;
      end
   end

   // Highest-priority pending event consumes the cycle: A > B > up > down > left > right
   always_comb begin
      state_next     = state_reg;
      cursor_next    = cursor_reg;
      cmd_id_next    = cmd_id_reg;
      cmd_valid_next = cmd_valid_reg;
      case (state_reg)
         HIDDEN: begin
            if (menu_en)
               state_next = BROWSE;
         end
         BROWSE: begin
            if (!menu_en) begin
               state_next = HIDDEN;
            end else if (a_ev_reg) begin
               if (cursor_reg[2] || move_en[cursor_reg[1:0]]) begin
                  cmd_id_next    = cursor_reg;
                  cmd_valid_next = 1'b1;
                  state_next     = ISSUE;
               end
            end else if (b_ev_reg) begin
               cursor_next = 3'd4;
            end else if (dir_ev_reg[0]) begin
               if (!cursor_reg[2])
                  cursor_next = (cursor_reg == 3'd3) ? 3'd5 : 3'd4;
            end else if (dir_ev_reg[1]) begin
               if (cursor_reg[2])
                  cursor_next = (cursor_reg == 3'd5) ? 3'd3 : 3'd2;
            end else if (dir_ev_reg[2]) begin
               // top row toggles 4<->5; bottom row wraps through 2-bit arithmetic
               if (cursor_reg[2])
                  cursor_next = cursor_reg ^ 3'd1;
               else
                  cursor_next = {1'b0, cursor_reg[1:0] - 2'd1};
            end else if (dir_ev_reg[3]) begin
               if (cursor_reg[2])
                  cursor_next = cursor_reg ^ 3'd1;
               else
                  cursor_next = {1'b0, cursor_reg[1:0] + 2'd1};
            end
         end
         ISSUE: begin
            // menu_en is deliberately ignored: a pending command is never withdrawn
            if (cmd_valid_reg && cmd.cmd_ready) begin
               cmd_valid_next = 1'b0;
               state_next     = WAIT_DROP;
            end
         end
         WAIT_DROP: begin
            if (!menu_en)
               state_next = HIDDEN;
         end
         default: state_next = HIDDEN;
      endcase
   end

   assign menu_vis      = (state_reg == BROWSE) || (state_reg == ISSUE);
   assign hl_on         = (state_reg == ISSUE) || ((state_reg == BROWSE) && blink_reg);
   assign cursor        = cursor_reg;
   assign cmd.cmd_valid = cmd_valid_reg;
   assign cmd.cmd_id    = cmd_id_reg;
endmodule

// File: tb/tb_battle_menu_ctrl.sv
module tb_battle_menu_ctrl;
   logic       clk;
   logic       rst;
   logic       menu_en;
   logic [3:0] move_en;
   logic       btn_up, btn_down, btn_left, btn_right, btn_a, btn_b;
   logic       menu_vis;
   logic [2:0] cursor;
   logic       hl_on;

   battle_menu_ctrl_if bus();

   battle_menu_ctrl #(
      .REPEAT_DELAY(24'd8),
      .REPEAT_RATE (24'd4),
      .BLINK_CYCLES(24'd3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .menu_en  (menu_en),
      .move_en  (move_en),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_left (btn_left),
      .btn_right(btn_right),
      .btn_a    (btn_a),
      .btn_b    (btn_b),
      .cmd      (bus),
      .menu_vis (menu_vis),
      .cursor   (cursor),
      .hl_on    (hl_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // btns = {a, b, up, down, left, right}
   typedef struct {
      logic [5:0] btns;
      logic [3:0] move_en;
      logic [2:0] exp_cursor;
      logic       exp_valid;
      logic [2:0] exp_id;
      logic       exp_vis;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];
   vec_t sb_q[$];
   vec_t exp_v;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   task automatic set_btns(input logic [5:0] b);
      {btn_a, btn_b, btn_up, btn_down, btn_left, btn_right} = b;
   endtask

   // One-cycle press; the cursor reacts two clocks after the press is applied
   task automatic pulse(input logic [5:0] b);
      set_btns(b);
      step();
      set_btns(6'b0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{6'b000100, 4'b1111, 3'd2, 1'b0, 3'd0, 1'b1}; // down 4->2
      vecs[1]  = '{6'b000001, 4'b1111, 3'd3, 1'b0, 3'd0, 1'b1}; // right 2->3
      vecs[2]  = '{6'b000001, 4'b1111, 3'd0, 1'b0, 3'd0, 1'b1}; // right wraps 3->0
      vecs[3]  = '{6'b001000, 4'b1111, 3'd4, 1'b0, 3'd0, 1'b1}; // up 0->4
      vecs[4]  = '{6'b000001, 4'b1111, 3'd5, 1'b0, 3'd0, 1'b1}; // right 4->5
      vecs[5]  = '{6'b000010, 4'b1111, 3'd4, 1'b0, 3'd0, 1'b1}; // left 5->4
      vecs[6]  = '{6'b000001, 4'b1111, 3'd5, 1'b0, 3'd0, 1'b1}; // right 4->5
      vecs[7]  = '{6'b001000, 4'b1111, 3'd5, 1'b0, 3'd0, 1'b1}; // up on top row: no-op
      vecs[8]  = '{6'b000100, 4'b1111, 3'd3, 1'b0, 3'd0, 1'b1}; // down 5->3
      vecs[9]  = '{6'b000100, 4'b1111, 3'd3, 1'b0, 3'd0, 1'b1}; // down on bottom row: no-op
      vecs[10] = '{6'b001000, 4'b1111, 3'd5, 1'b0, 3'd0, 1'b1}; // up 3->5
      vecs[11] = '{6'b000100, 4'b1111, 3'd3, 1'b0, 3'd0, 1'b1}; // down 5->3
      vecs[12] = '{6'b010000, 4'b1111, 3'd4, 1'b0, 3'd0, 1'b1}; // B -> 4
      vecs[13] = '{6'b000100, 4'b1111, 3'd2, 1'b0, 3'd0, 1'b1}; // down 4->2
      vecs[14] = '{6'b000010, 4'b1111, 3'd1, 1'b0, 3'd0, 1'b1}; // left 2->1
      vecs[15] = '{6'b100000, 4'b1101, 3'd1, 1'b0, 3'd0, 1'b1}; // A on disabled move 1
      vecs[16] = '{6'b000001, 4'b1101, 3'd2, 1'b0, 3'd0, 1'b1}; // right 1->2
      vecs[17] = '{6'b100000, 4'b1101, 3'd2, 1'b1, 3'd2, 1'b1}; // A issues move 2

      rst = 1'b0;
      menu_en = 1'b0;
      move_en = 4'b1111;
      set_btns(6'b0);
      bus.cmd_ready = 1'b0;

      // Reset state
      step();
      step();
      chk("reset_cursor", cursor, 4);
      chk("reset_vis", menu_vis, 0);
      chk("reset_hl", hl_on, 0);
      chk("reset_valid", bus.cmd_valid, 0);
      chk("reset_id", bus.cmd_id, 0);
      rst = 1'b1;
      step();
      chk("hidden_vis", menu_vis, 0);

      // Table-driven browsing and first issue
      menu_en = 1'b1;
      step();
      chk("browse_vis", menu_vis, 1);
      for (int i = 0; i < NV; i++) begin
         move_en = vecs[i].move_en;
         sb_q.push_back(vecs[i]);
         pulse(vecs[i].btns);
         exp_v = sb_q.pop_front();
         $display("vec %0d: btns=%b cursor=%0d valid=%0d id=%0d vis=%0d",
                  i, exp_v.btns, cursor, bus.cmd_valid, bus.cmd_id, menu_vis);
         chk($sformatf("vec%0d_cursor", i), cursor, exp_v.exp_cursor);
         chk($sformatf("vec%0d_valid", i), bus.cmd_valid, exp_v.exp_valid);
         chk($sformatf("vec%0d_id", i), bus.cmd_id, exp_v.exp_id);
         chk($sformatf("vec%0d_vis", i), menu_vis, exp_v.exp_vis);
      end

      // ISSUE holds with cmd_ready low; buttons ignored
      set_btns(6'b000001);
      for (int k = 0; k < 5; k++) begin
         step();
         set_btns(6'b0);
         chk("issue_hold_valid", bus.cmd_valid, 1);
         chk("issue_hold_id", bus.cmd_id, 2);
         chk("issue_hold_cursor", cursor, 2);
         chk("issue_hl", hl_on, 1);
      end
      bus.cmd_ready = 1'b1;
      step();
      bus.cmd_ready = 1'b0;
      chk("hs_valid_clear", bus.cmd_valid, 0);
      chk("waitdrop_vis", menu_vis, 0);
      chk("waitdrop_hl", hl_on, 0);
      $display("handshake: cmd_id=2 accepted");

      // WAIT_DROP with menu_en still high: A does nothing
      set_btns(6'b100000);
      for (int k = 0; k < 4; k++) begin
         step();
         set_btns(6'b0);
         chk("waitdrop_no_cmd", bus.cmd_valid, 0);
         chk("waitdrop_stay_hidden", menu_vis, 0);
      end
      menu_en = 1'b0;
      step();
      menu_en = 1'b1;
      step();
      chk("reenter_vis", menu_vis, 1);
      chk("reenter_cursor", cursor, 2);

      // Auto-repeat: bring cursor to 0, then hold left for 20 cycles
      pulse(6'b000010);
      pulse(6'b000010);
      chk("pre_repeat_cursor", cursor, 0);
      btn_left = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         int ec;
         step();
         if (k == 20) btn_left = 1'b0;
         // first step 2 clocks after the press, then +8, +12, +16 later
         if (k < 2)       ec = 0;
         else if (k < 10) ec = 3;
         else if (k < 14) ec = 2;
         else if (k < 18) ec = 1;
         else             ec = 0;
         chk($sformatf("repeat_k%0d", k), cursor, ec);
      end
      $display("auto-repeat: final cursor=%0d", cursor);

      // A and left together at cursor 5, cmd_ready already high
      pulse(6'b001000);
      chk("t4_up", cursor, 4);
      pulse(6'b000001);
      chk("t4_right", cursor, 5);
      bus.cmd_ready = 1'b1;
      pulse(6'b100010);
      chk("t4_valid", bus.cmd_valid, 1);
      chk("t4_id", bus.cmd_id, 5);
      chk("t4_cursor", cursor, 5);
      step();
      bus.cmd_ready = 1'b0;
      chk("t4_hs_first_cycle", bus.cmd_valid, 0);
      set_btns(6'b100000);
      for (int k = 0; k < 6; k++) begin
         step();
         set_btns(k[0] ? 6'b100000 : 6'b0);
         chk("t4_no_second_cmd", bus.cmd_valid, 0);
      end
      set_btns(6'b0);
      $display("handshake: cmd_id=5 accepted");

      // menu_en drop during ISSUE keeps cmd_valid
      menu_en = 1'b0;
      step();
      menu_en = 1'b1;
      step();
      step();
      pulse(6'b100000);
      chk("t5_valid", bus.cmd_valid, 1);
      menu_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t5_hold_valid", bus.cmd_valid, 1);
         chk("t5_hold_vis", menu_vis, 1);
      end
      bus.cmd_ready = 1'b1;
      step();
      bus.cmd_ready = 1'b0;
      chk("t5_hs", bus.cmd_valid, 0);
      step();
      chk("t5_hidden_vis", menu_vis, 0);
      chk("t5_hidden_cursor", cursor, 5);

      // Reset mid-ISSUE
      menu_en = 1'b1;
      step();
      pulse(6'b100000);
      chk("t5b_valid", bus.cmd_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async_valid", bus.cmd_valid, 0);
      chk("rst_async_cursor", cursor, 4);
      chk("rst_async_vis", menu_vis, 0);
      chk("rst_async_id", bus.cmd_id, 0);
      menu_en = 1'b0;
      step();
      rst = 1'b1;
      step();

      // Blink in BROWSE, then forced on in ISSUE
      menu_en = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk($sformatf("blink_k%0d", k), hl_on, ((k - 1) / 3) % 2);
      end
      pulse(6'b100000);
      chk("blink_issue_valid", bus.cmd_valid, 1);
      chk("blink_issue_hl", hl_on, 1);
      bus.cmd_ready = 1'b1;
      step();
      bus.cmd_ready = 1'b0;
      chk("blink_waitdrop_hl", hl_on, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
